// File: rtl/target_scheduler_pkg.sv
// Shared tracker definitions: scheduler state encoding, target count and coordinate width.
package target_scheduler_pkg;

   localparam int NUM_TARGETS = 16;
   localparam int IDX_W       = 4;
   localparam int COORD_W     = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      HOLD  = 2'd2,
      LOCK  = 2'd3
   } sched_state_t;

   // Lowest set flag index; 0 when no flag is set.
   function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_TARGETS-1:0] flags);
      lowest_set = '0;
      for (int i = NUM_TARGETS-1; i >= 0; i--)
         if (flags[i]) lowest_set = IDX_W'(i);
   endfunction

endpackage

// File: rtl/target_scheduler_rr_next_finder.sv
// Round-robin search: first flagged index strictly after cur_idx_i (mod 16),
// falling back to cur_idx_i itself when nothing else is flagged.
module rr_next_finder
   import target_scheduler_pkg::*;
(
   input  logic [NUM_TARGETS-1:0] flags_i,
   input  logic [IDX_W-1:0]       cur_idx_i,
   output logic [IDX_W-1:0]       next_idx_o,
   output logic                   any_o
);

   // Walk from the farthest offset down so the nearest flagged index wins.
   always_comb begin
      next_idx_o = cur_idx_i;
      any_o      = |flags_i;
      for (int k = NUM_TARGETS-1; k >= 1; k--)
         if (flags_i[cur_idx_i + IDX_W'(k)]) next_idx_o = cur_idx_i + IDX_W'(k);
   end

endmodule

// File: rtl/target_scheduler.sv
// Per-frame target selection: auto rotation with dwell, coasting through short
// drop-outs, and operator lock-on override.
//
//   state | meaning
//   IDLE  | nothing selected, sel_valid low, coordinates frozen
//   TRACK | following sel_idx, dwell counts frames before rotating
//   HOLD  | selected target lost, coordinate coasted for up to LOST_FRAMES
//   LOCK  | operator lock-on, sel_idx follows locked_idx
module target_scheduler
   import target_scheduler_pkg::*;
#(
   parameter int DWELL_FRAMES = 30,
   parameter int LOST_FRAMES  = 4
)(
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           frame_start,
   input  logic [NUM_TARGETS-1:0]         aim_detected_all,
   input  logic [NUM_TARGETS*COORD_W-1:0] aim_x_all,
   input  logic [NUM_TARGETS*COORD_W-1:0] aim_y_all,
   input  logic                           is_locked,
   input  logic [IDX_W-1:0]               locked_idx,
   output logic                           sel_valid,
   output logic [IDX_W-1:0]               sel_idx,
   output logic [COORD_W-1:0]             sel_x,
   output logic [COORD_W-1:0]             sel_y,
   output logic                           sel_new,
   output logic [1:0]                     sel_state
);

   localparam int DW_W   = $clog2(DWELL_FRAMES) + 1;
   localparam int LOST_W = $clog2(LOST_FRAMES + 1);

   sched_state_t       state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               valid_q, valid_d;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic               new_q, new_d;
   logic [DW_W-1:0]    dwell_q, dwell_d;
   logic [LOST_W-1:0]  lost_q, lost_d;

   logic [COORD_W-1:0] x_arr [NUM_TARGETS];
   logic [COORD_W-1:0] y_arr [NUM_TARGETS];
   logic [IDX_W-1:0]   rr_idx;
   logic               any_det;

   for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_unpack
      assign x_arr[i] = aim_x_all[i*COORD_W +: COORD_W];
      assign y_arr[i] = aim_y_all[i*COORD_W +: COORD_W];
   end

   rr_next_finder u_rr (
      .flags_i    (aim_detected_all),
      .cur_idx_i  (idx_q),
      .next_idx_o (rr_idx),
      .any_o      (any_det)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      x_d     = x_q;
      y_d     = y_q;
      dwell_d = dwell_q;
      lost_d  = lost_q;
      new_d   = 1'b0;
      if (frame_start) begin
         if (is_locked) begin
            state_d = LOCK;
            idx_d   = locked_idx;
            valid_d = 1'b1;
            dwell_d = '0;
            lost_d  = '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (any_det) begin
                     state_d = TRACK;
                     idx_d   = lowest_set(aim_detected_all);
                     valid_d = 1'b1;
                     dwell_d = '0;
                  end else begin
                     valid_d = 1'b0;
                  end
               end
               TRACK: begin
                  if (!aim_detected_all[idx_q]) begin
                     state_d = HOLD;
                     lost_d  = LOST_W'(1);
                  end else if (dwell_q == DW_W'(DWELL_FRAMES - 1)) begin
                     idx_d   = rr_idx;
                     dwell_d = '0;
                  end else begin
                     dwell_d = dwell_q + 1'b1;
                  end
               end
               HOLD: begin
                  if (aim_detected_all[idx_q]) begin
                     state_d = TRACK;
                     dwell_d = '0;
                     lost_d  = '0;
                  end else if (lost_q == LOST_W'(LOST_FRAMES)) begin
                     lost_d  = '0;
                     dwell_d = '0;
                     if (any_det) begin
                        state_d = TRACK;
                        idx_d   = rr_idx;
                     end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                     end
                  end else begin
                     lost_d = lost_q + 1'b1;
                  end
               end
               LOCK: begin
                  dwell_d = '0;
                  lost_d  = '0;
                  if (aim_detected_all[idx_q]) begin
                     state_d = TRACK;
                  end else begin
                     state_d = IDLE;
                     valid_d = 1'b0;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
         // Coordinates only refresh when the chosen target is actually seen.
         if (valid_d && aim_detected_all[idx_d]) begin
            x_d = x_arr[idx_d];
            y_d = y_arr[idx_d];
         end
         new_d = valid_d && (!valid_q || (idx_d != idx_q));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         valid_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         new_q   <= 1'b0;
         dwell_q <= '0;
         lost_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         x_q     <= x_d;
         y_q     <= y_d;
         new_q   <= new_d;
         dwell_q <= dwell_d;
         lost_q  <= lost_d;
      end
   end

   assign sel_valid = valid_q;
   assign sel_idx   = idx_q;
   assign sel_x     = x_q;
   assign sel_y     = y_q;
   assign sel_new   = new_q;
   assign sel_state = state_q;

endmodule

// File: tb/tb_target_scheduler.sv
// Directed scenarios plus randomized frames, checked every cycle against a
// frame-level reference model of the selection rules.
module tb_target_scheduler;

   localparam int DW = 2;
   localparam int LF = 4;
   localparam int M_IDLE = 0, M_TRACK = 1, M_HOLD = 2, M_LOCK = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         frame_start = 1'b0;
   logic [15:0]  aim_detected_all = '0;
   logic [159:0] aim_x_all = '0;
   logic [159:0] aim_y_all = '0;
   logic         is_locked = 1'b0;
   logic [3:0]   locked_idx = '0;
   logic         sel_valid, sel_new;
   logic [3:0]   sel_idx;
   logic [9:0]   sel_x, sel_y;
   logic [1:0]   sel_state;

   logic [9:0] cx [16];
   logic [9:0] cy [16];

   int m_state, m_idx, m_valid, m_x, m_y, m_new, m_dwell, m_lost;
   int n_checks = 0;
   int n_pass   = 0;

   target_scheduler #(.DWELL_FRAMES(DW), .LOST_FRAMES(LF)) dut (
      .clk              (clk),
      .reset            (reset),
      .frame_start      (frame_start),
      .aim_detected_all (aim_detected_all),
      .aim_x_all        (aim_x_all),
      .aim_y_all        (aim_y_all),
      .is_locked        (is_locked),
      .locked_idx       (locked_idx),
      .sel_valid        (sel_valid),
      .sel_idx          (sel_idx),
      .sel_x            (sel_x),
      .sel_y            (sel_y),
      .sel_new          (sel_new),
      .sel_state        (sel_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int expv);
      n_checks++;
      if (obs == expv) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, expv, $time);
   endtask

   function automatic int rr_search(input logic [15:0] f, input int cur);
      for (int k = 1; k <= 16; k++)
         if (f[(cur + k) % 16]) return (cur + k) % 16;
      return cur;
   endfunction

   task automatic model_reset();
      m_state = M_IDLE; m_idx = 0; m_valid = 0; m_x = 0; m_y = 0;
      m_new = 0; m_dwell = 0; m_lost = 0;
   endtask

   task automatic model_frame();
      logic [15:0] f;
      int prev_idx, prev_valid;
      f = aim_detected_all;
      prev_idx = m_idx;
      prev_valid = m_valid;
      if (is_locked) begin
         m_state = M_LOCK; m_idx = int'(locked_idx); m_valid = 1; m_dwell = 0; m_lost = 0;
      end else if (m_state == M_IDLE) begin
         if (f != 0) begin
            m_state = M_TRACK; m_idx = rr_search(f, 15); m_valid = 1; m_dwell = 0;
         end
      end else if (m_state == M_TRACK) begin
         if (!f[m_idx]) begin
            m_state = M_HOLD; m_lost = 1;
         end else if (m_dwell == DW - 1) begin
            m_idx = rr_search(f, m_idx); m_dwell = 0;
         end else m_dwell++;
      end else if (m_state == M_HOLD) begin
         if (f[m_idx]) begin
            m_state = M_TRACK; m_dwell = 0; m_lost = 0;
         end else if (m_lost == LF) begin
            m_lost = 0; m_dwell = 0;
            if (f != 0) begin m_state = M_TRACK; m_idx = rr_search(f, m_idx); end
            else begin m_state = M_IDLE; m_valid = 0; end
         end else m_lost++;
      end else begin
         m_dwell = 0; m_lost = 0;
         if (f[m_idx]) m_state = M_TRACK;
         else begin m_state = M_IDLE; m_valid = 0; end
      end
      if (m_valid != 0 && f[m_idx]) begin
         m_x = int'(cx[m_idx]); m_y = int'(cy[m_idx]);
      end
      m_new = (m_valid != 0 && (prev_valid == 0 || prev_idx != m_idx)) ? 1 : 0;
   endtask

   task automatic tick(input bit fs, input bit rst);
      for (int i = 0; i < 16; i++) begin
         aim_x_all[i*10 +: 10] = cx[i];
         aim_y_all[i*10 +: 10] = cy[i];
      end
      frame_start = fs;
      reset = rst;
      @(posedge clk);
      #1;
      if (rst) model_reset();
      else if (fs) model_frame();
      else m_new = 0;
      check("state", int'(sel_state), m_state);
      check("valid", int'(sel_valid), m_valid);
      check("idx",   int'(sel_idx),   m_idx);
      check("x",     int'(sel_x),     m_x);
      check("y",     int'(sel_y),     m_y);
      check("new",   int'(sel_new),   m_new);
      frame_start = 1'b0;
      reset = 1'b0;
   endtask

   task automatic frame();
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
   endtask

   initial begin
      int exp_seq [7];
      int r;
      exp_seq = '{0, 0, 4, 4, 15, 15, 0};
      for (int i = 0; i < 16; i++) begin cx[i] = 10'(i * 7); cy[i] = 10'(i * 3 + 1); end
      model_reset();
      #1;

      // Reset wins over a coincident frame pulse.
      aim_detected_all = 16'hFFFF;
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      check("rst_state", int'(sel_state), 0);
      check("rst_valid", int'(sel_valid), 0);

      // No targets: stay idle, never pulse.
      aim_detected_all = 16'h0000;
      for (int n = 0; n < 3; n++) begin
         frame();
         check("empty_valid", int'(sel_valid), 0);
         check("empty_state", int'(sel_state), 0);
      end

      // Rotation with wrap 15 -> 0.
      aim_detected_all = 16'h8011;
      for (int n = 0; n < 7; n++) begin
         tick(1'b1, 1'b0);
         check("rr_seq", int'(sel_idx), exp_seq[n]);
         check("rr_new", int'(sel_new), (n == 0 || n == 2 || n == 4 || n == 6) ? 1 : 0);
         tick(1'b0, 1'b0);
      end

      // Coast through a 3-frame drop-out on idx 4.
      tick(1'b0, 1'b1);
      cx[4] = 10'd100; cy[4] = 10'd50;
      aim_detected_all = 16'h0010;
      frame();
      check("hold_pre_idx", int'(sel_idx), 4);
      aim_detected_all = 16'h0000;
      cx[4] = 10'd999; cy[4] = 10'd999;
      for (int n = 0; n < 3; n++) begin
         tick(1'b1, 1'b0);
         check("hold_state", int'(sel_state), 2);
         check("hold_x", int'(sel_x), 100);
         check("hold_y", int'(sel_y), 50);
         check("hold_new", int'(sel_new), 0);
         tick(1'b0, 1'b0);
      end
      cx[4] = 10'd100; cy[4] = 10'd50;
      aim_detected_all = 16'h0010;
      tick(1'b1, 1'b0);
      check("hold_back_state", int'(sel_state), 1);
      check("hold_back_idx", int'(sel_idx), 4);
      check("hold_back_new", int'(sel_new), 0);
      tick(1'b0, 1'b0);

      // Lost for LOST_FRAMES+1 frames with nothing detected -> idle.
      aim_detected_all = 16'h0000;
      for (int n = 0; n < LF + 1; n++) begin
         tick(1'b1, 1'b0);
         check("lost_valid", int'(sel_valid), (n == LF) ? 0 : 1);
      end
      check("lost_state", int'(sel_state), 0);

      // Lock override and release.
      tick(1'b0, 1'b1);
      aim_detected_all = 16'h0204;
      frame();
      check("lk_pre_idx", int'(sel_idx), 2);
      is_locked = 1'b1; locked_idx = 4'd9;
      tick(1'b1, 1'b0);
      check("lk_state", int'(sel_state), 3);
      check("lk_idx", int'(sel_idx), 9);
      check("lk_new", int'(sel_new), 1);
      tick(1'b0, 1'b0);
      is_locked = 1'b0;
      for (int n = 0; n < 3; n++) begin
         tick(1'b1, 1'b0);
         check("rel_idx", int'(sel_idx), (n < 2) ? 9 : 2);
         check("rel_state", int'(sel_state), 1);
      end

      // Reset together with frame while locked.
      is_locked = 1'b1; locked_idx = 4'd5;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      check("rst_lk_state", int'(sel_state), 0);
      check("rst_lk_x", int'(sel_x), 0);
      check("rst_lk_idx", int'(sel_idx), 0);
      is_locked = 1'b0;

      // Randomized frames, including back-to-back pulses.
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0) aim_detected_all = 16'h0000;
         else if (r >= 6) aim_detected_all = 16'($urandom) & 16'($urandom);
         is_locked = ($urandom_range(0, 9) == 0);
         locked_idx = 4'($urandom_range(0, 15));
         for (int i = 0; i < 16; i++) begin
            cx[i] = 10'($urandom_range(0, 1023));
            cy[i] = 10'($urandom_range(0, 1023));
         end
         tick($urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/target_scheduler.md
TARGET_SCHEDULER -- requirements
Module: target_scheduler

Interface
REQ-001 SHALL have parameter DWELL_FRAMES, default 30, frames spent on one auto-selected target before rotating (min 1).
REQ-002 SHALL have parameter LOST_FRAMES, default 4, frames the last coordinate is coasted after the selected target disappears (min 1).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 frame_start  input  1  one-cycle pulse per video frame; the only evaluation instant.
REQ-006 aim_detected_all  input  16  per-target detected flags from the tracker.
REQ-007 aim_x_all  input  16x10 packed  per-target centre x.
REQ-008 aim_y_all  input  16x10 packed  per-target centre y.
REQ-009 is_locked  input  1  operator lock-on active.
REQ-010 locked_idx  input  4  operator-locked target index.
REQ-011 sel_valid  output  1  a target is selected and sel_x/sel_y are meaningful.
REQ-012 sel_idx  output  4  selected target index.
REQ-013 sel_x, sel_y  output  10 each  selected target coordinate.
REQ-014 sel_new  output  1  one-cycle pulse when the selection changes.
REQ-015 sel_state  output  2  current FSM state encoding.

Function
REQ-016 SHALL implement states IDLE, TRACK, HOLD, LOCK; all transitions and output updates occur only on the cycle after a frame_start cycle (latency 1); between pulses every output holds.
REQ-017 RR-next SHALL be the first detected index strictly after sel_idx, searching modulo 16 (15 wraps to 0); if sel_idx is the only detected index, RR-next = sel_idx.
REQ-018 LOCK priority: on frame_start with is_locked=1, from any state, SHALL enter/stay LOCK with sel_idx=locked_idx, sel_valid=1.
REQ-019 LOCK with is_locked=0: SHALL go TRACK (dwell=0, same idx) if aim_detected_all[sel_idx]=1, else IDLE.
REQ-020 IDLE: if any flag set, SHALL go TRACK with sel_idx = lowest detected index, dwell=0, sel_valid=1; else remain, sel_valid=0.
REQ-021 TRACK: if current target undetected, SHALL go HOLD with lost=1; else if dwell=DWELL_FRAMES-1, SHALL set sel_idx=RR-next, dwell=0; else dwell+1.
REQ-022 HOLD: current target detected -> TRACK, dwell=0; else if lost=LOST_FRAMES -> TRACK at RR-next (dwell=0) when any flag set, else IDLE with sel_valid=0; else lost+1.
REQ-023 sel_valid SHALL remain 1 throughout HOLD; sel_x/sel_y SHALL freeze at their last values in HOLD and IDLE.
REQ-024 sel_x/sel_y SHALL load aim_x_all[new sel_idx]/aim_y_all[new sel_idx] on every evaluation where the new sel_idx is detected (in LOCK, when locked_idx is undetected, coordinates freeze).
REQ-025 sel_new SHALL pulse for exactly one cycle when sel_idx changes with sel_valid=1, or sel_valid rises 0->1; never on unchanged evaluations.
REQ-026 dwell counter SHALL be ceil(log2(DWELL_FRAMES))+1 bits and lost counter sized for LOST_FRAMES; neither SHALL overflow or wrap.
REQ-027 frame_start asserted on consecutive cycles SHALL be treated as independent evaluations.

Reset
REQ-028 reset SHALL force IDLE, sel_valid=0, sel_idx=0, sel_x=0, sel_y=0, sel_new=0, dwell=0, lost=0, at the next clk edge.
REQ-029 reset SHALL dominate frame_start in the same cycle; reset mid-HOLD or mid-LOCK discards all history.

Structure
REQ-030 SHALL place state enum (IDLE=0, TRACK=1, HOLD=2, LOCK=3), NUM_TARGETS=16 and COORD_W=10 in the shared tracker package.
REQ-031 SHALL implement RR-next search as combinational sub-module rr_next_finder (inputs flags, current idx; outputs next idx, any).

Verification
REQ-032 Flags 0x0000, 3 frame pulses -> sel_valid=0, state IDLE, sel_new never asserted.
REQ-033 DWELL_FRAMES=2, flags 0x8011 -> sel_idx sequence 0,0,4,4,15,15,0 across frames; sel_new on each change incl. 15->0 wrap.
REQ-034 Tracking idx 4 at (100,50), flag 4 drops for 3 frames (LOST_FRAMES=4) then returns -> HOLD, coordinate frozen at (100,50), back to TRACK idx 4, no sel_new.
REQ-035 Flag 4 drops and flags=0 for LOST_FRAMES+1 frames -> IDLE, sel_valid falls on that evaluation.
REQ-036 is_locked=1, locked_idx=9 while TRACK idx 2 -> LOCK idx 9 one cycle after frame_start; release with flag 9 set -> TRACK idx 9, dwell=0.
REQ-037 reset asserted together with frame_start while in LOCK -> all outputs zero, state IDLE next cycle.
